fmap_capture_multi: RTL and testbench

// - Multi-channel feature-map capture engine; successor to the single-channel 256-bit capture path.
// - Samples whole conv-layer columns (all channels at once) into a column FIFO.
// - Drains them as packed BRAM_DW-bit words into the local result BRAM for every channel enabled in a runtime mask.
// - Sits between any conv/ReLU stage output and BRAM port A; replaces external per-channel base-offset muxing.

---
 rtl/fmap_capture_pkg.sv | 28 ++
 rtl/fmap_capture_multi_col_fifo.sv | 71 +++++++
 rtl/fmap_capture_multi.sv | 251 +++++++++++++++++++++++++
 tb/tb_fmap_capture_multi.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_capture_pkg.sv
// ----------------------------------------------------------------------------
// fmap_capture_pkg
//   Shared types and helpers for the multi-channel feature-map capture engine.
//   - cap_state_t : capture FSM state encoding
//   - wpc()       : BRAM words needed to hold one column of one channel
//   - word_addr() : untruncated BRAM word address for (channel, column, word)
// ----------------------------------------------------------------------------
package fmap_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    function automatic int wpc(input int pix_h, input int ppw);
        return (pix_h + ppw - 1) / ppw;
    endfunction

    // Channel regions are CH_STRIDE apart; inside a region columns are
    // WPC words apart, so a dropped column simply leaves its words unwritten.
    function automatic int word_addr(input int base, input int stride, input int wpc_n,
                                     input int ch, input int col, input int w);
        return base + ch * stride + col * wpc_n + w;
    endfunction

endpackage

// File: rtl/fmap_capture_multi_col_fifo.sv
// ----------------------------------------------------------------------------
// col_fifo
//   Synchronous first-word-fall-through FIFO holding whole captured columns.
//   Ports:
//     clk, rst    clock, async active-high reset (FIFO empties on reset)
//     push        write push_data (ignored when full unless popping this cycle)
//     push_data   WIDTH-bit entry
//     pop         remove head entry (ignored when empty)
//     pop_data    current head entry, valid while !empty
//     full/empty  occupancy flags
//     count       number of stored entries (0..DEPTH)
//   DEPTH must be a power of 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module col_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fmap_capture_multi.sv
// ----------------------------------------------------------------------------
// fmap_capture_multi
//   Captures NUM_COLS columns (all channels at once) into a column FIFO and
//   writes them as packed BRAM_DW-bit words into the result BRAM for every
//   channel enabled in the mask latched at start.
//   Ports:
//     clk, rst       clock, async active-high reset
//     start          arm one frame capture (pulse, ignored while busy)
//     chan_mask      channels to store, sampled on an accepted start
//     valid_col      data_col valid this cycle (only used in CAPTURE)
//     data_col       one column, [channel][pixel][bit]
//     bram_addr_a    BRAM port A address   (0 when not writing)
//     bram_wrdata_a  BRAM port A data      (0 when not writing)
//     bram_we_a      BRAM port A write enable
//     busy           CAPTURE or DRAIN
//     write_done     frame fully written, held in DONE
//     overflow       sticky, a column was dropped this frame
//     cols_accepted  columns counted this frame
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset, waiting for start
//   CAPTURE | counting columns, pushing them into the FIFO, writer running
//   DRAIN   | all columns seen, writer emptying the FIFO
//   DONE    | frame written (or empty mask); a new start re-arms
// ----------------------------------------------------------------------------
module fmap_capture_multi
    import fmap_capture_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int PIX_H        = 24,
    parameter int NUM_COLS     = 24,
    parameter int BRAM_DW      = 256,
    parameter int ADDR_W       = 12,
    parameter int BASE_ADDR    = 0,
    parameter int CH_STRIDE    = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [NUM_CHANNELS-1:0]                        chan_mask,
    input  logic                                           valid_col,
    input  logic [NUM_CHANNELS-1:0][PIX_H-1:0][DATA_WIDTH-1:0] data_col,
    output logic [ADDR_W-1:0]                              bram_addr_a,
    output logic [BRAM_DW-1:0]                             bram_wrdata_a,
    output logic                                           bram_we_a,
    output logic                                           busy,
    output logic                                           write_done,
    output logic                                           overflow,
    output logic [$clog2(NUM_COLS+1)-1:0]                  cols_accepted
);

    localparam int PPW    = BRAM_DW / DATA_WIDTH;
    localparam int WPC    = wpc(PIX_H, PPW);
    localparam int CNT_W  = $clog2(NUM_COLS + 1);
    localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int W_W    = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int PAY_W  = NUM_CHANNELS * PIX_H * DATA_WIDTH;
    localparam int FIFO_W = PAY_W + COL_W;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [NUM_CHANNELS-1:0][PIX_H-1:0][DATA_WIDTH-1:0] col_t;

    cap_state_t                state;
    cap_state_t                state_nxt;
    logic [NUM_CHANNELS-1:0]   mask_q;

    logic                      start_acc;
    logic                      cap_valid;
    logic                      last_col;
    logic                      push_ok;
    logic                      pop;

    logic [FIFO_W-1:0]         fifo_rd;
    logic                      fifo_empty;
    logic                      fifo_full_unused;
    logic [FCNT_W-1:0]         fifo_count;

    logic                      wr_active;
    logic [CH_W-1:0]           wr_ch;
    logic [W_W-1:0]            wr_w;
    col_t                      col_buf;
    logic [COL_W-1:0]          col_idx_q;

    logic [CH_W-1:0]           ch_first;
    logic [CH_W-1:0]           ch_next;
    logic                      has_next;
    logic                      last_beat;

    logic [PIX_H-1:0][DATA_WIDTH-1:0]          ch_pix;
    logic [WPC-1:0][PPW-1:0][DATA_WIDTH-1:0]   pix_pad;
    logic [BRAM_DW-1:0]                        wr_word;

    assign start_acc = start && ((state == IDLE) || (state == DONE));
    assign cap_valid = (state == CAPTURE) && valid_col;
    assign last_col  = cap_valid && (cols_accepted == CNT_W'(NUM_COLS - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (chan_mask != '0) ? CAPTURE : DONE;
                end
            end
            CAPTURE: begin
                if (last_col) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !wr_active) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == CAPTURE) || (state == DRAIN);
        write_done = (state == DONE);
    end

    // ---------------- frame counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q        <= '0;
            cols_accepted <= '0;
            overflow      <= 1'b0;
        end else if (start_acc) begin
            mask_q        <= chan_mask;
            cols_accepted <= '0;
            overflow      <= 1'b0;
        end else if (cap_valid) begin
            cols_accepted <= cols_accepted + 1'b1;
            if (!push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------- column FIFO ----------------
    // The frame column index travels with the payload so the writer can
    // address columns correctly after earlier ones were dropped.
    assign push_ok = cap_valid && ((fifo_count < FCNT_W'(FIFO_DEPTH)) || pop);

    col_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_col_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data ({cols_accepted[COL_W-1:0], data_col}),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- writer sequencer ----------------
    // Lowest enabled channel overall, and lowest enabled channel above wr_ch.
    always_comb begin
        ch_first = '0;
        ch_next  = '0;
        has_next = 1'b0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (mask_q[c]) begin
                ch_first = CH_W'(c);
            end
            if (mask_q[c] && (c > int'(wr_ch))) begin
                ch_next  = CH_W'(c);
                has_next = 1'b1;
            end
        end
    end

    assign last_beat = wr_active && (wr_w == W_W'(WPC - 1)) && !has_next;
    // Loading the next column on the last beat keeps columns back-to-back.
    assign pop       = !fifo_empty && (!wr_active || last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_active <= 1'b0;
            wr_ch     <= '0;
            wr_w      <= '0;
            col_buf   <= '0;
            col_idx_q <= '0;
        end else if (pop) begin
            col_buf   <= fifo_rd[PAY_W-1:0];
            col_idx_q <= fifo_rd[FIFO_W-1:PAY_W];
            wr_active <= 1'b1;
            wr_ch     <= ch_first;
            wr_w      <= '0;
        end else if (wr_active) begin
            if (wr_w == W_W'(WPC - 1)) begin
                wr_w <= '0;
                if (has_next) begin
                    wr_ch <= ch_next;
                end else begin
                    wr_active <= 1'b0;
                end
            end else begin
                wr_w <= wr_w + 1'b1;
            end
        end
    end

    // Pixels beyond PIX_H in the last word stay zero.
    always_comb begin
        ch_pix  = col_buf[wr_ch];
        pix_pad = '0;
        for (int p = 0; p < PIX_H; p++) begin
            pix_pad[p / PPW][p % PPW] = ch_pix[p];
        end
    end

    assign wr_word = pix_pad[wr_w];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_we_a     <= 1'b0;
            bram_addr_a   <= '0;
            bram_wrdata_a <= '0;
        end else if (wr_active) begin
            bram_we_a     <= 1'b1;
            bram_addr_a   <= ADDR_W'(word_addr(BASE_ADDR, CH_STRIDE, WPC,
                                               int'(wr_ch), int'(col_idx_q), int'(wr_w)));
            bram_wrdata_a <= wr_word;
        end else begin
            bram_we_a     <= 1'b0;
            bram_addr_a   <= '0;
            bram_wrdata_a <= '0;
        end
    end

endmodule

// File: tb/tb_fmap_capture_multi.sv
// ----------------------------------------------------------------------------
// tb_fmap_capture_multi
//   Directed frames through fmap_capture_multi; every BRAM write is recorded
//   and compared against hand-derived address/data sequences.
// ----------------------------------------------------------------------------
module tb_fmap_capture_multi;

    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int PH  = 24;
    localparam int NC  = 24;
    localparam int BDW = 256;
    localparam int AW  = 12;

    typedef logic [NCH-1:0][PH-1:0][DW-1:0] col_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [NCH-1:0]   chan_mask = '0;
    logic             valid_col = 1'b0;
    col_t             data_col = '0;
    logic [AW-1:0]    bram_addr_a;
    logic [BDW-1:0]   bram_wrdata_a;
    logic             bram_we_a;
    logic             busy;
    logic             write_done;
    logic             overflow;
    logic [4:0]       cols_accepted;

    fmap_capture_multi #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .PIX_H(PH), .NUM_COLS(NC),
        .BRAM_DW(BDW), .ADDR_W(AW), .BASE_ADDR(0), .CH_STRIDE(64), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask),
        .valid_col(valid_col), .data_col(data_col),
        .bram_addr_a(bram_addr_a), .bram_wrdata_a(bram_wrdata_a), .bram_we_a(bram_we_a),
        .busy(busy), .write_done(write_done), .overflow(overflow),
        .cols_accepted(cols_accepted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0]  wq_addr[$];
    logic [BDW-1:0] wq_data[$];
    int first_we_cyc = -1;
    int last_we_cyc  = -1;
    int done_cyc     = -1;
    int col0_cyc     = 0;
    int idle_nonzero = 0;
    int both_err     = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bram_we_a) begin
                wq_addr.push_back(bram_addr_a);
                wq_data.push_back(bram_wrdata_a);
                last_we_cyc = cyc;
                if (first_we_cyc < 0) first_we_cyc = cyc;
            end else if (bram_addr_a != '0 || bram_wrdata_a != '0) begin
                idle_nonzero++;
            end
            if (busy && write_done) both_err++;
            if (write_done && done_cyc < 0) done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [BDW-1:0] got, input logic [BDW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int ch, input int col, input int row);
        int v;
        v = (ch << 12) | (col << 5) | row;
        return v[DW-1:0];
    endfunction

    function automatic col_t make_col(input int col);
        col_t c;
        for (int ch = 0; ch < NCH; ch++)
            for (int r = 0; r < PH; r++)
                c[ch][r] = pix(ch, col, r);
        return c;
    endfunction

    function automatic logic [BDW-1:0] exp_word(input int ch, input int col, input int w);
        logic [BDW-1:0] v;
        v = '0;
        for (int i = 0; i < 16; i++)
            if (w * 16 + i < PH) v[i*DW +: DW] = pix(ch, col, w * 16 + i);
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mon;
        wq_addr.delete();
        wq_data.delete();
        first_we_cyc = -1;
        last_we_cyc  = -1;
        done_cyc     = -1;
    endtask

    task automatic do_start(input logic [NCH-1:0] m);
        start     = 1'b1;
        chan_mask = m;
        tick;
        start     = 1'b0;
    endtask

    // One frame of NC columns, one column every gap cycles; at column inj_col
    // a start with a full mask is pulsed (the DUT is busy then).
    task automatic feed(input int gap, input int inj_col);
        for (int col = 0; col < NC; col++) begin
            valid_col = 1'b1;
            data_col  = make_col(col);
            if (col == 0) col0_cyc = cyc;
            if (col == inj_col) begin
                start     = 1'b1;
                chan_mask = 4'b1111;
            end
            tick;
            valid_col = 1'b0;
            start     = 1'b0;
            for (int g = 1; g < gap; g++) tick;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!write_done && n < 3000) begin
            tick;
            n++;
        end
        check({tag, " done_timeout"}, write_done, 1);
        repeat (3) tick;
    endtask

    // Expected write order: column ascending, enabled channel ascending, word.
    task automatic verify_writes(input string tag, input logic [NC-1:0] acc, input logic [NCH-1:0] m);
        int idx;
        idx = 0;
        for (int col = 0; col < NC; col++)
            for (int ch = 0; ch < NCH; ch++)
                for (int w = 0; w < 2; w++)
                    if (acc[col] && m[ch]) begin
                        if (idx < wq_addr.size()) begin
                            check($sformatf("%s wr%0d addr", tag, idx), wq_addr[idx], ch * 64 + col * 2 + w);
                            check($sformatf("%s wr%0d data", tag, idx), wq_data[idx], exp_word(ch, col, w));
                        end
                        idx++;
                    end
        check({tag, " nwrites"}, wq_addr.size(), idx);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " we"},       bram_we_a, 0);
        check({tag, " addr"},     bram_addr_a, 0);
        check({tag, " data"},     bram_wrdata_a, 0);
        check({tag, " busy"},     busy, 0);
        check({tag, " done"},     write_done, 0);
        check({tag, " overflow"}, overflow, 0);
        check({tag, " cols"},     cols_accepted, 0);
    endtask

    initial begin
        int ch_bad;

        // reset state
        repeat (3) tick;
        check_all_zero("rst");
        rst = 1'b0;
        tick;
        check_all_zero("idle");

        // mask 0001, columns at the writer's rate
        reset_mon;
        do_start(4'b0001);
        check("t1 busy", busy, 1);
        feed(2, -1);
        wait_done("t1");
        verify_writes("t1", 24'hFFFFFF, 4'b0001);
        if (wq_data.size() > 1) check("t1 word1 upper", wq_data[1][255:128], 0);
        check("t1 first_we_latency", first_we_cyc - col0_cyc, 3);
        check("t1 done_after_last",  done_cyc - last_we_cyc, 1);
        check("t1 overflow", overflow, 0);
        check("t1 cols",     cols_accepted, 24);
        check("t1 busy",     busy, 0);

        // mask 1111, columns 8 cycles apart
        reset_mon;
        do_start(4'b1111);
        feed(8, -1);
        wait_done("t2");
        verify_writes("t2", 24'hFFFFFF, 4'b1111);
        if (wq_addr.size() > 45) check("t2 ch2col5w1 addr", wq_addr[45], 139);
        check("t2 overflow", overflow, 0);

        // mask 1111 back-to-back: only columns 0,1,2,3,4,9,17 fit
        reset_mon;
        do_start(4'b1111);
        feed(1, -1);
        wait_done("t3");
        verify_writes("t3", 24'h02021F, 4'b1111);
        check("t3 overflow", overflow, 1);
        check("t3 cols",     cols_accepted, 24);
        check("t3 done",     write_done, 1);

        // mask 1010, input mask changed and start pulsed mid-frame
        reset_mon;
        do_start(4'b1010);
        chan_mask = 4'b0101;
        feed(8, 5);
        wait_done("t4");
        verify_writes("t4", 24'hFFFFFF, 4'b1010);
        ch_bad = 0;
        foreach (wq_addr[i])
            if (wq_addr[i] < 64 || (wq_addr[i] >= 128 && wq_addr[i] < 192)) ch_bad++;
        check("t4 ch0_ch2_writes", ch_bad, 0);
        check("t4 overflow", overflow, 0);

        // empty mask from IDLE: straight to DONE, columns ignored
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        reset_mon;
        check("t5 idle_done", write_done, 0);
        do_start(4'b0000);
        check("t5 done_next", write_done, 1);
        check("t5 busy",      busy, 0);
        feed(1, -1);
        repeat (5) tick;
        check("t5 cols",    cols_accepted, 0);
        check("t5 nwrites", wq_addr.size(), 0);
        check("t5 done",    write_done, 1);

        // reset mid-frame, then a clean frame
        reset_mon;
        do_start(4'b0001);
        for (int col = 0; col < 10; col++) begin
            valid_col = 1'b1;
            data_col  = make_col(col);
            tick;
            valid_col = 1'b0;
            tick;
        end
        #2 rst = 1'b1;
        #1 check_all_zero("t6 rst");
        tick;
        tick;
        rst = 1'b0;
        tick;
        reset_mon;
        do_start(4'b0001);
        feed(2, -1);
        wait_done("t6");
        verify_writes("t6", 24'hFFFFFF, 4'b0001);
        check("t6 overflow", overflow, 0);

        check("idle_outputs_zero", idle_nonzero, 0);
        check("busy_and_done",     both_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
